// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// column-drive rotation constants and the key-map decode.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Column drive patterns, one bit low, in scan order.
    localparam logic [3:0] COL_0 = 4'b1110;
    localparam logic [3:0] COL_1 = 4'b1101;
    localparam logic [3:0] COL_2 = 4'b1011;
    localparam logic [3:0] COL_3 = 4'b0111;

    // Rows read all-high when no key in the driven column is down.
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Rotate the low bit one place left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    // True when exactly one row line is pulled low.
    function automatic logic one_row_low(input logic [3:0] rows);
        logic r;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Decode driven column + low row into the key value printed on the pad.
    function automatic logic [3:0] key_map(input logic [3:0] col, input logic [3:0] row);
        logic [3:0] code;
        code = 4'h0;
        case (col)
            COL_3: begin
                case (row)
                    4'b0111: code = 4'h1;
                    4'b1011: code = 4'h4;
                    4'b1101: code = 4'h7;
                    4'b1110: code = 4'hE;
                    default: code = 4'h0;
                endcase
            end
            COL_2: begin
                case (row)
                    4'b0111: code = 4'h2;
                    4'b1011: code = 4'h5;
                    4'b1101: code = 4'h8;
                    4'b1110: code = 4'h0;
                    default: code = 4'h0;
                endcase
            end
            COL_1: begin
                case (row)
                    4'b0111: code = 4'h3;
                    4'b1011: code = 4'h6;
                    4'b1101: code = 4'h9;
                    4'b1110: code = 4'hF;
                    default: code = 4'h0;
                endcase
            end
            COL_0: begin
                case (row)
                    4'b0111: code = 4'hA;
                    4'b1011: code = 4'hB;
                    4'b1101: code = 4'hC;
                    4'b1110: code = 4'hD;
                    default: code = 4'h0;
                endcase
            end
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Flops reset to all-high so the rows read as idle out of reset.
module kp_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows_i,
    output logic [3:0] rows_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two back-to-back flops; only sync_q is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= ROWS_IDLE;
            sync_q <= ROWS_IDLE;
        end else begin
            meta_q <= rows_i;
            sync_q <= meta_q;
        end
    end

    assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a valid/ready event output.
// Optional autorepeat while a key is held is enabled by defining the macro
// KEYPAD_AUTOREPEAT_EN; without it each press yields exactly one event and
// no repeat counters exist.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 8,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DB_N     = 8'(DEBOUNCE_SCANS);

    // Reject out-of-range configurations at elaboration.
    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_chk_div
        $error("keypad_scanner: SCAN_DIV out of range");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255) begin : g_chk_db
        $error("keypad_scanner: DEBOUNCE_SCANS out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 || REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_chk_rpt
        $error("keypad_scanner: REPEAT_DELAY/REPEAT_RATE out of range");
    end

    logic [3:0]  rows_s;
    logic [15:0] div_q;
    logic        sample;
    kp_state_e   state_q;
    logic [3:0]  kpc_q;
    logic [3:0]  row_q;
    logic [3:0]  cap_code_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic        held_q;
    logic        valid_q;
    logic [3:0]  code_q;
    logic        ovr_q;
    logic        evt;
    logic [3:0]  evt_code;
    logic        hs;

    kp_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rows_i  (kpr),
        .rows_o  (rows_s)
    );

    assign sample  = (div_q == DIV_LAST);
    assign cnt_inc = cnt_q + 8'd1;
    assign hs      = valid_q & key_ready;

    // Column dwell counter; wraps on the sample cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (sample) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0] rpt_cnt_q;
    logic        rpt_phase_q;
    logic [15:0] rpt_next;
    logic        rpt_fire;

    assign rpt_next = rpt_cnt_q + 16'd1;
    assign rpt_fire = rpt_phase_q ? (rpt_next == 16'(REPEAT_RATE))
                                  : (rpt_next == 16'(REPEAT_DELAY));

    // Repeat timer: restarts on each new press, holds during release debounce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else if (state_q == ST_SCAN || state_q == ST_DEBOUNCE) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else if (state_q == ST_PRESSED && sample && rows_s != ROWS_IDLE) begin
            if (rpt_fire) begin
                rpt_cnt_q   <= '0;
                rpt_phase_q <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_next;
            end
        end
    end
`endif

    // Event strobe: fires on the sample that completes a press debounce
    // (or a repeat interval), carrying the code to publish.
    always_comb begin
        evt      = 1'b0;
        evt_code = cap_code_q;
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (DEBOUNCE_SCANS == 1 && one_row_low(rows_s)) begin
                        evt      = 1'b1;
                        evt_code = key_map(kpc_q, rows_s);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == row_q && cnt_inc == DB_N) begin
                        evt = 1'b1;
                    end
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                ST_PRESSED: begin
                    if (rows_s != ROWS_IDLE && rpt_fire) begin
                        evt = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Scan/debounce FSM; all state changes happen on sample cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SCAN;
            kpc_q      <= COL_0;
            row_q      <= ROWS_IDLE;
            cap_code_q <= '0;
            cnt_q      <= '0;
            held_q     <= 1'b0;
        end else if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_row_low(rows_s)) begin
                        row_q      <= rows_s;
                        cap_code_q <= key_map(kpc_q, rows_s);
                        cnt_q      <= 8'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q <= ST_PRESSED;
                            held_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DEBOUNCE;
                        end
                    end else begin
                        kpc_q <= next_col(kpc_q);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == row_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DB_N) begin
                            state_q <= ST_PRESSED;
                            held_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_SCAN;
                        kpc_q   <= next_col(kpc_q);
                    end
                end
                ST_PRESSED: begin
                    if (rows_s == ROWS_IDLE) begin
                        cnt_q <= 8'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q <= ST_SCAN;
                            held_q  <= 1'b0;
                            kpc_q   <= next_col(kpc_q);
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rows_s == ROWS_IDLE) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DB_N) begin
                            state_q <= ST_SCAN;
                            held_q  <= 1'b0;
                            kpc_q   <= next_col(kpc_q);
                        end
                    end else begin
                        state_q <= ST_PRESSED;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    // Output event register with valid/ready handshake and overrun tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (evt) begin
                if (!valid_q || hs) begin
                    valid_q <= 1'b1;
                    code_q  <= evt_code;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            if (ovr_clr && !(evt && valid_q && !hs)) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign kpc       = kpc_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign overrun   = ovr_q;

endmodule
